// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch stage and the control unit:
// instruction classes, the idle code word, fetch state encoding.
package isa_pkg;

    localparam int ISA_INSTR_W = 24;

    localparam logic [1:0] CLS_ALU = 2'b00;
    localparam logic [1:0] CLS_IMM = 2'b01;
    localparam logic [1:0] CLS_MEM = 2'b10;
    localparam logic [1:0] CLS_BR  = 2'b11;

    // Class 00 with alu=6'b111111: decodes as a harmless no-op.
    localparam logic [ISA_INSTR_W-1:0] NOP_CODE = 24'h0003F0;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_FETCH   = 2'd1,
        FS_WAIT_BR = 2'd2
    } fetch_state_e;

    function automatic logic [1:0] instr_class(input logic [ISA_INSTR_W-1:0] instr);
        return instr[ISA_INSTR_W-1 -: 2];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched word and its address.
// A push on the same edge as a pop replaces the entry and keeps it valid.
module fetch_skid_buf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue stage: PC, synchronous imem reads, one-entry skid,
// valid/stall handoff to decode, and fetch freeze behind a branch word.
module instr_fetch
    import isa_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter int                 INSTR_W  = 24,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_CODE = isa_pkg::NOP_CODE
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] code,
    output logic               code_valid,
    output logic [ADDR_W-1:0]  code_pc,
    input  logic               stall,
    input  logic               br_resolve,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target
);

    // Handshake: decode takes the word on code/code_pc at a rising edge where
    // code_valid=1 and stall=0; code stays stable while stall=1.

    fetch_state_e               state;
    logic [ADDR_W-1:0]          pc;
    logic                       inflight;
    logic                       br_accepted;

    logic                       skid_valid;
    logic [INSTR_W+ADDR_W-1:0]  skid_dout;

    logic                       ret_is_br;
    logic                       accept;
    logic                       slot_free;
    logic                       load_from_skid;
    logic                       skid_push;
    logic                       issue;
    logic                       resolve;
    logic [ADDR_W-1:0]          ret_pc;

    // pc only moves on issue or resolve, and resolve never overlaps a read,
    // so the returning word always belongs to pc-1.
    assign ret_pc         = pc - ADDR_W'(1);
    assign ret_is_br      = inflight && (instr_class(imem_data) == CLS_BR);
    assign accept         = code_valid && !stall;
    assign slot_free      = !code_valid || accept;
    assign load_from_skid = accept && skid_valid;
    assign skid_push      = inflight && (!slot_free || load_from_skid);
    assign issue          = (state == FS_FETCH) && !skid_valid && !stall && !ret_is_br;
    assign resolve        = (state == FS_WAIT_BR) && br_accepted && br_resolve;

    assign imem_en   = issue;
    assign imem_addr = pc;

    fetch_skid_buf #(.W(INSTR_W + ADDR_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (skid_push),
        .pop   (load_from_skid),
        .din   ({imem_data, ret_pc}),
        .valid (skid_valid),
        .dout  (skid_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FS_IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            br_accepted <= 1'b0;
            code        <= NOP_CODE;
            code_valid  <= 1'b0;
            code_pc     <= '0;
        end else begin
            inflight <= issue;

            if (issue) begin
                pc <= pc + ADDR_W'(1);
            end else if (resolve && br_taken) begin
                pc <= br_target;
            end

            case (state)
                FS_IDLE:    state <= FS_FETCH;
                FS_FETCH:   if (ret_is_br) state <= FS_WAIT_BR;
                FS_WAIT_BR: if (resolve) state <= FS_FETCH;
                default:    state <= FS_IDLE;
            endcase

            if (resolve) begin
                br_accepted <= 1'b0;
            end else if (state == FS_WAIT_BR && accept && instr_class(code) == CLS_BR) begin
                br_accepted <= 1'b1;
            end

            if (load_from_skid) begin
                code       <= skid_dout[INSTR_W+ADDR_W-1:ADDR_W];
                code_pc    <= skid_dout[ADDR_W-1:0];
                code_valid <= 1'b1;
            end else if (inflight && slot_free) begin
                code       <= imem_data;
                code_pc    <= ret_pc;
                code_valid <= 1'b1;
            end else if (accept) begin
                code       <= NOP_CODE;
                code_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed latency/stall/branch/reset steps plus a
// random phase checked against a program-order model of fetched words.
module tb_instr_fetch;

  localparam logic [23:0] NOP = 24'h0003F0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data = '0;
  logic [23:0] code;
  logic        code_valid;
  logic [7:0]  code_pc;
  logic        stall;
  logic        br_resolve;
  logic        br_taken;
  logic [7:0]  br_target;

  logic        imem_en2;
  logic [7:0]  imem_addr2;
  logic [23:0] imem_data2 = '0;
  logic [23:0] code2;
  logic        code_valid2;
  logic [7:0]  code_pc2;
  logic        zero_bit = 1'b0;
  logic [7:0]  zero_addr = '0;

  logic [23:0] mem [256];

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;

  // model state: next address the program order demands
  logic        mon_en = 1'b0;
  logic [7:0]  next_fetch = '0;
  logic        fetch_blocked = 1'b0;
  logic        br_acc_seen = 1'b0;
  logic [7:0]  br_pc = '0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .code(code), .code_valid(code_valid), .code_pc(code_pc),
    .stall(stall), .br_resolve(br_resolve), .br_taken(br_taken), .br_target(br_target)
  );

  instr_fetch #(.RESET_PC(8'hFE)) dut2 (
    .clk(clk), .rst_n(rst_n), .imem_en(imem_en2), .imem_addr(imem_addr2),
    .imem_data(imem_data2), .code(code2), .code_valid(code_valid2), .code_pc(code_pc2),
    .stall(zero_bit), .br_resolve(zero_bit), .br_taken(zero_bit), .br_target(zero_addr)
  );

  always @(posedge clk) begin
    if (imem_en) imem_data <= mem[imem_addr];
    if (imem_en2) imem_data2 <= {16'h0000, imem_addr2};
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (imem_en) begin
        chk("no_wrong_path", {31'd0, fetch_blocked}, 32'd0);
        chk("issue_addr", {24'd0, imem_addr}, {24'd0, next_fetch});
        if (!fetch_blocked) begin
          exp_q.push_back({next_fetch, mem[next_fetch]});
          if (mem[next_fetch][23:22] == 2'b11) fetch_blocked = 1'b1;
          else next_fetch = next_fetch + 8'd1;
        end
      end
      if (!code_valid) chk("nop_when_idle", {8'd0, code}, {8'd0, NOP});
      if (code_valid && !stall) begin
        chk("accept_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("accept_code", {8'd0, code}, {8'd0, e[23:0]});
          chk("accept_pc", {24'd0, code_pc}, {24'd0, e[31:24]});
          acc_cnt++;
          if (e[23:22] == 2'b11) begin
            br_acc_seen = 1'b1;
            br_pc = e[31:24];
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    stall = 1'b0;
    br_resolve = 1'b0;
    br_taken = 1'b0;
    br_target = '0;
    repeat (2) @(posedge clk);
    exp_q.delete();
    next_fetch = 8'h00;
    fetch_blocked = 1'b0;
    br_acc_seen = 1'b0;
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  // called at posedge+1 once the branch has been accepted; DUT samples at next edge
  task automatic pulse_resolve(input logic taken, input logic [7:0] tgt);
    br_resolve = 1'b1;
    br_taken = taken;
    br_target = tgt;
    next_fetch = taken ? tgt : br_pc + 8'd1;
    fetch_blocked = 1'b0;
    br_acc_seen = 1'b0;
  endtask

  task automatic end_pulse();
    br_resolve = 1'b0;
    br_taken = 1'b0;
  endtask

  task automatic wait_branch(input string tag);
    tick();
    for (int i = 0; i < 40 && !br_acc_seen; i++) tick();
    chk(tag, {31'd0, br_acc_seen}, 32'd1);
  endtask

  // from the posedge+1 after reset release up to the negedge after E2
  task automatic startup_check(input string tag);
    at_neg();
    chk({tag, "_rst_en"}, {31'd0, imem_en}, 32'd0);
    chk({tag, "_rst_valid"}, {31'd0, code_valid}, 32'd0);
    chk({tag, "_rst_code"}, {8'd0, code}, {8'd0, NOP});
    chk({tag, "_rst_pc"}, {24'd0, code_pc}, 32'd0);
    chk({tag, "_rst_pc2"}, {24'd0, code_pc2}, 32'd0);
    at_neg();
    chk({tag, "_e1_en"}, {31'd0, imem_en}, 32'd1);
    chk({tag, "_e1_addr"}, {24'd0, imem_addr}, 32'h00);
    chk({tag, "_e1_valid"}, {31'd0, code_valid}, 32'd0);
    chk({tag, "_e1_addr2"}, {24'd0, imem_addr2}, 32'hFE);
    at_neg();
    chk({tag, "_e2_addr"}, {24'd0, imem_addr}, 32'h01);
    chk({tag, "_e2_valid"}, {31'd0, code_valid}, 32'd0);
    chk({tag, "_e2_addr2"}, {24'd0, imem_addr2}, 32'hFF);
    at_neg();
    chk({tag, "_out_valid"}, {31'd0, code_valid}, 32'd1);
    chk({tag, "_out_code"}, {8'd0, code}, {8'd0, mem[0]});
    chk({tag, "_out_pc"}, {24'd0, code_pc}, 32'd0);
    chk({tag, "_wrap_addr2"}, {24'd0, imem_addr2}, 32'h00);
    chk({tag, "_wrap_pc2"}, {24'd0, code_pc2}, 32'hFE);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] exp_addr [5];
    logic [7:0] exp_pc2 [5];
    exp_addr = '{8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
    exp_pc2  = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h01};

    for (int i = 0; i < 256; i++) mem[i] = 24'h001000 | 24'(i);
    mem[0] = 24'h000010;
    mem[1] = 24'h400000;
    mem[2] = 24'h800001;
    mem[3] = 24'h000020;
    mem[4] = 24'hC03000;

    // stream 0..3, branch at 4 taken to 0x40
    do_reset();
    startup_check("a");
    for (int k = 3; k <= 7; k++) begin
      if (k > 3) at_neg();
      chk("a_en", {31'd0, imem_en}, {31'd0, k <= 5});
      if (k <= 5) chk("a_addr", {24'd0, imem_addr}, {24'd0, exp_addr[k-3]});
      chk("a_valid", {31'd0, code_valid}, 32'd1);
      chk("a_code", {8'd0, code}, {8'd0, mem[k-3]});
      chk("a_pc", {24'd0, code_pc}, k - 3);
      if (k <= 6) chk("a_wrap_pc2", {24'd0, code_pc2}, {24'd0, exp_pc2[k-3]});
    end
    tick();
    chk("a_br_seen", {31'd0, br_acc_seen}, 32'd1);
    pulse_resolve(1'b1, 8'h40);
    tick();
    end_pulse();
    at_neg();
    chk("a_tgt_en", {31'd0, imem_en}, 32'd1);
    chk("a_tgt_addr", {24'd0, imem_addr}, 32'h40);
    chk("a_bubble", {31'd0, code_valid}, 32'd0);
    at_neg();
    chk("a_bubble2", {31'd0, code_valid}, 32'd0);
    at_neg();
    chk("a_tgt_valid", {31'd0, code_valid}, 32'd1);
    chk("a_tgt_code", {8'd0, code}, {8'd0, mem[8'h40]});
    chk("a_tgt_pc", {24'd0, code_pc}, 32'h40);

    // stall with a word in flight, spurious resolve in FETCH, branch not taken
    do_reset();
    startup_check("b");
    tick();
    stall = 1'b1;
    br_resolve = 1'b1;
    br_taken = 1'b1;
    br_target = 8'h80;
    for (int k = 4; k <= 7; k++) begin
      at_neg();
      chk("b_hold_code", {8'd0, code}, 32'h400000);
      chk("b_hold_pc", {24'd0, code_pc}, 32'd1);
      chk("b_no_issue", {31'd0, imem_en}, 32'd0);
      tick();
      end_pulse();
      if (k == 6) stall = 1'b0;
    end
    at_neg();
    chk("b_skid_code", {8'd0, code}, 32'h800001);
    chk("b_skid_pc", {24'd0, code_pc}, 32'd2);
    chk("b_next_addr", {24'd0, imem_addr}, 32'd3);
    wait_branch("b_br_timeout");
    pulse_resolve(1'b0, 8'h77);
    tick();
    end_pulse();
    for (int i = 0; i < 10 && !imem_en; i++) at_neg();
    chk("b_resume_en", {31'd0, imem_en}, 32'd1);
    chk("b_resume_addr", {24'd0, imem_addr}, 32'd5);

    // reset while waiting on a branch with the skid full
    do_reset();
    startup_check("c");
    tick();
    tick();
    tick();
    stall = 1'b1;
    at_neg();
    at_neg();
    chk("c_pre_code", {8'd0, code}, {8'd0, mem[3]});
    chk("c_pre_en", {31'd0, imem_en}, 32'd0);
    #2;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("c_async_valid", {31'd0, code_valid}, 32'd0);
    chk("c_async_code", {8'd0, code}, {8'd0, NOP});
    chk("c_async_pc", {24'd0, code_pc}, 32'd0);
    chk("c_async_en", {31'd0, imem_en}, 32'd0);
    chk("c_async_addr", {24'd0, imem_addr}, 32'd0);
    do_reset();
    startup_check("c2");

    // random program, random stall and branch outcomes
    rst_n = 1'b0;
    mon_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [1:0] cls;
      cls = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      mem[i] = {cls, 22'($urandom)};
    end
    do_reset();
    acc_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      stall = ($urandom_range(0, 2) == 0);
      if (br_resolve) end_pulse();
      else if (br_acc_seen && $urandom_range(0, 2) == 0)
        pulse_resolve(1'($urandom_range(0, 1)), 8'($urandom));
      else if (!br_acc_seen && $urandom_range(0, 19) == 0) begin
        br_resolve = 1'b1;
        br_taken = 1'b1;
        br_target = 8'($urandom);
      end
    end
    chk("rand_progress", {31'd0, acc_cnt >= 100}, 32'd1);
    mon_en = 1'b0;
    stall = 1'b0;
    end_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
